// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle radix-2 multiply/divide unit writing architectural HI/LO.
// Build option: define MDU_EARLY_TERM_EN to end multiplies once the multiplier has no set bits left.
module mdu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q;
  logic             neg_res_q;
  logic             neg_rem_q;
  logic [W2-1:0]    acc_q;
  logic [W2-1:0]    mcand_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;
  logic             div_zero_q;

  // Operand magnitudes and sign bookkeeping captured at start.
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    a_neg = op[0] & a[WIDTH-1];
    b_neg = op[0] & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  logic [W2-1:0]    acc_d;
  logic [W2-1:0]    mcand_d;
  logic [WIDTH-1:0] opb_d;
  logic [WIDTH:0]   trial_d;
  logic [W2-1:0]    prod_d;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;
  logic             last_d;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    opb_d   = opb_q;
    trial_d = '0;
    prod_d  = '0;
    hi_d    = hi_q;
    lo_d    = lo_q;

    if (is_div_q) begin
      // Restoring step: shift {rem, dividend} left, try subtracting the divisor from the top.
      trial_d = acc_q[W2-1:WIDTH-1] - {1'b0, opb_q};
      if (!trial_d[WIDTH]) acc_d = {trial_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                 acc_d = {acc_q[W2-2:0], 1'b0};
      lo_d = neg_res_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
      hi_d = neg_rem_q ? -acc_d[W2-1:WIDTH] : acc_d[W2-1:WIDTH];
      if (opb_q == '0) lo_d = '1;
    end else begin
      if (opb_q[0]) acc_d = acc_q + mcand_q;
      mcand_d = mcand_q << 1;
      opb_d   = opb_q >> 1;
      prod_d  = neg_res_q ? -acc_d : acc_d;
      hi_d    = prod_d[W2-1:WIDTH];
      lo_d    = prod_d[WIDTH-1:0];
    end

    last_d = (cnt_q == CNT_W'(1));
`ifdef MDU_EARLY_TERM_EN
    if (!is_div_q && opb_d == '0) last_d = 1'b1;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      acc_q      <= '0;
      mcand_q    <= '0;
      opb_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            is_div_q   <= op[1];
            neg_res_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            acc_q      <= op[1] ? {{WIDTH{1'b0}}, a_mag} : '0;
            mcand_q    <= {{WIDTH{1'b0}}, a_mag};
            opb_q      <= b_mag;
            cnt_q      <= CNT_W'(WIDTH);
            busy_q     <= 1'b1;
            div_zero_q <= 1'b0;
            state_q    <= S_CALC;
          end else begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
          end
        end
        S_CALC: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_d;
          opb_q   <= opb_d;
          cnt_q   <= cnt_q - CNT_W'(1);
          if (last_d) begin
            // Result lands with the FIX entry so hi/lo are already valid while done is high.
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= is_div_q && (opb_q == '0);
            done_q     <= 1'b1;
            state_q    <= S_FIX;
          end
        end
        S_FIX: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: cycle-by-cycle comparison against an arithmetic reference model
// plus directed literal expectations; honours MDU_EARLY_TERM_EN when defined.
module tb_mdu_seq;

  localparam int W       = 32;
  localparam int TIMEOUT = 200;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_err    = 0;

  mdu_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of one operation, from plain integer arithmetic.
  function automatic void compute(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rdz);
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    rdz = 1'b0;
    rh  = '0;
    rl  = '0;
    if (!o[1]) begin
      if (o[0]) p = sx * sy;
      else      p = {32'b0, x} * {32'b0, y};
      rh = p[63:32];
      rl = p[31:0];
    end else if (y == '0) begin
      rl  = '1;
      rh  = x;
      rdz = 1'b1;
    end else if (!o[0]) begin
      rl = x / y;
      rh = x % y;
    end else begin
      q  = sx / sy;
      r  = sx % sy;
      rl = 32'(q);
      rh = 32'(r);
    end
  endfunction

  function automatic int calc_len(input logic [1:0] o, input logic [W-1:0] y);
    int           n;
    logic [W-1:0] m;
    n = W;
    m = (o[0] && y[W-1]) ? -y : y;
`ifdef MDU_EARLY_TERM_EN
    if (!o[1]) begin
      n = 1;
      for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
    end
`endif
    if (m == '1) n = n;  // keeps m referenced in the default build
    return n;
  endfunction

  // Reference model: tracks what the outputs must be after each rising edge.
  logic         m_valid = 1'b0;
  logic         m_busy, m_done, m_dz;
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  logic         p_dz;
  int           m_left;

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b1;
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_dz    = 1'b0;
      m_hi    = '0;
      m_lo    = '0;
      m_left  = 0;
    end else if (m_valid) begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1;
          m_dz   = 1'b0;
          compute(op, a, b, p_hi, p_lo, p_dz);
          m_left = calc_len(op, b);
        end else begin
          if (hi_we) m_hi = wdata;
          if (lo_we) m_lo = wdata;
        end
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_hi   = p_hi;
          m_lo   = p_lo;
          m_dz   = p_dz;
          m_done = 1'b1;
        end
      end else begin
        m_busy = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("div_zero", div_zero, m_dz);
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
  endtask

  // Entered just after the first edge of an operation; returns edges-until-done and busy cycles.
  task automatic wait_done(input bit junk, output int lat, output int bcnt);
    lat  = 1;
    bcnt = 0;
    while (!done && lat < TIMEOUT) begin
      if (busy) bcnt++;
      if (junk) begin
        start = 1'($urandom_range(0, 1));
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
        hi_we = 1'($urandom_range(0, 1));
        lo_we = 1'($urandom_range(0, 1));
        wdata = $urandom;
      end
      @(negedge clk); #1;
      lat++;
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    if (busy) bcnt++;
    check("done_seen", done, 1'b1);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit junk, output int lat, output int bcnt);
    launch(o, x, y);
    wait_done(junk, lat, bcnt);
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 15));
      5:       return 32'($urandom_range(0, 2000)) - 32'd1000;
      default: return $urandom;
    endcase
  endfunction

  int lat, bcnt;
  int exp_short;

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
`ifdef MDU_EARLY_TERM_EN
    exp_short = 3;
`else
    exp_short = 33;
`endif
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dz", div_zero, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    rst_n = 1'b1;

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bcnt);
    check("multu_lat", lat, 33);
    check("multu_busy_cycles", bcnt, 33);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    run_op(2'b01, 32'hFFFF_FFF9, 32'd3, 1'b0, lat, bcnt);
    check("mult_lat", lat, exp_short);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);

    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, bcnt);
    check("div_lat", lat, 33);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    run_op(2'b10, 32'd100, 32'd7, 1'b0, lat, bcnt);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    run_op(2'b10, 32'h1234, 32'd0, 1'b0, lat, bcnt);
    check("dz_lat", lat, 33);
    check("dz_flag", div_zero, 1'b1);
    check("dz_lo", lo, 32'hFFFF_FFFF);
    check("dz_hi", hi, 32'h0000_1234);

    run_op(2'b00, 32'd2, 32'd3, 1'b0, lat, bcnt);
    check("dz_cleared", div_zero, 1'b0);
    check("mul6_lo", lo, 32'd6);
    check("mul6_hi", hi, 32'd0);

    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, bcnt);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'h0);
    check("ovf_dz", div_zero, 1'b0);

    // Collisions while busy: second start and a direct HI write are both ignored.
    launch(2'b00, 32'd3, 32'd4);
    start = 1'b1; op = 2'b10; a = 32'd9; b = 32'd5;
    @(negedge clk); #1;
    start = 1'b0; hi_we = 1'b1; wdata = 32'hAA;
    @(negedge clk); #1;
    hi_we = 1'b0;
    check("busy_hi_hold", hi, 32'h0);
    check("busy_lo_hold", lo, 32'h8000_0000);
    wait_done(1'b0, lat, bcnt);
    check("coll_lo", lo, 32'd12);
    check("coll_hi", hi, 32'd0);

    // Start and lo_we together in IDLE: the operation wins.
    @(negedge clk); #1;
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd7; lo_we = 1'b1; wdata = 32'h55;
    @(negedge clk); #1;
    start = 1'b0; lo_we = 1'b0;
    wait_done(1'b0, lat, bcnt);
    check("start_lowe_lo", lo, 32'd35);

    // Direct writes in IDLE.
    @(negedge clk); #1;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthi", hi, 32'hDEAD_BEEF);
    check("mtlo", lo, 32'hDEAD_BEEF);

    // Reset in the middle of a divide.
    launch(2'b11, 32'hFFFF_FF00, 32'd3);
    repeat (8) @(negedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk); #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    rst_n = 1'b1;
    run_op(2'b10, 32'd100, 32'd7, 1'b0, lat, bcnt);
    check("postrst_lo", lo, 32'd14);
    check("postrst_hi", hi, 32'd2);

    // Randomized operations, idle writes and busy-window noise, all checked by the model.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk); #1;
        hi_we = 1'($urandom_range(0, 1)); lo_we = 1'($urandom_range(0, 1)); wdata = $urandom;
        @(negedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
      end
      run_op(2'($urandom), rnd_val(), rnd_val(), 1'($urandom_range(0, 1)), lat, bcnt);
    end
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
